// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants shared by the UART transmitter and the autobaud/parity detector:
// parity-mode encoding, transmitter FSM state encoding, the minimum bit
// divisor and small parity helpers.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Parity mode encoding as reported by the detector (2'b11 also means none)
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Transmitter FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Smallest usable bit period; the bit timer needs at least two clocks
    // per bit so that the "one clock before the end" decode always exists.
    localparam int unsigned DIV_MIN = 32'd2;

    // Latched per-frame framing options
    typedef struct packed {
        logic [1:0] mode;
        logic       stop2;
    } tx_cfg_t;

    // True when the mode inserts a parity bit
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity bit from the XOR of the data bits
    function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
        logic bit_s;
        case (mode)
            PAR_EVEN: bit_s = data_xor;
            PAR_ODD:  bit_s = ~data_xor;
            default:  bit_s = 1'b0;
        endcase
        return bit_s;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Loadable down-counter that measures one bit period. Loading with div
// makes the following div clocks form one bit; bit_end is high in the last
// of them and bit_pre_end in the one before it.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - reload the counter with div-1 at this edge
//   div          - bit period in clocks (caller guarantees div >= 2)
//   bit_end      - counter is 0: current clock is the last of the bit
//   bit_pre_end  - counter is 1: next clock is the last of the bit
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end,
    output logic             bit_pre_end
);

    logic [DIV_W-1:0] cnt_r;

    // Down-counter: reload on load, otherwise count towards zero and hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (load) begin
            cnt_r <= div - {{(DIV_W-1){1'b0}}, 1'b1};
        end else if (cnt_r != {DIV_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bit_end     = (cnt_r == {DIV_W{1'b0}});
    assign bit_pre_end = (cnt_r == {{(DIV_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
// Runtime-configurable UART transmitter. Bit period, parity mode and stop
// bit count are sampled together with the byte when a frame is accepted and
// stay fixed for that frame.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   baud_div      - clocks per bit (values below 2 are treated as 2)
//   parity_mode   - 00 none, 01 even, 10 odd, 11 none
//   stop2         - 1: two stop bits, 0: one stop bit
//   tx_start      - send request, taken when tx_ready is 1
//   din           - byte to send
//   tx_ready      - idle, a byte can be accepted
//   tx_done_tick  - high in the last clock of the frame
//   tx            - serial output, idle high, driven from a flop
// ---------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT  = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
    input  logic             tx_start,
    input  logic [DBIT-1:0]  din,
    output logic             tx_ready,
    output logic             tx_done_tick,
    output logic             tx
);

    localparam int IDX_W = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DBIT - 1);
    localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);

    logic [2:0]       state_r;
    logic [DBIT-1:0]  shreg_r;
    logic [IDX_W-1:0] bit_idx_r;
    logic             par_acc_r;
    logic             stop_cnt_r;
    tx_cfg_t          cfg_r;
    logic [DIV_W-1:0] div_r;
    logic             tx_r;
    logic             ready_r;
    logic             done_r;

    logic [DIV_W-1:0] div_clamped_s;
    logic [DIV_W-1:0] timer_div_s;
    logic             bit_end_s;
    logic             bit_pre_end_s;
    logic             last_stop_s;
    logic             frame_end_s;
    logic             accept_s;
    logic             timer_load_s;

    // Acceptance, bit-boundary and timer reload decisions
    always_comb begin
        if (baud_div < DIV_FLOOR) begin
            div_clamped_s = DIV_FLOOR;
        end else begin
            div_clamped_s = baud_div;
        end

        last_stop_s = (state_r == ST_STOP) && (stop_cnt_r == cfg_r.stop2);
        frame_end_s = last_stop_s && bit_end_s;

        // A request still high on the final edge of a frame is taken on that
        // edge, so the next start bit follows the stop bit with no idle gap.
        accept_s = tx_start && (ready_r || frame_end_s);

        if (accept_s) begin
            timer_div_s  = div_clamped_s;
            timer_load_s = 1'b1;
        end else begin
            timer_div_s  = div_r;
            timer_load_s = bit_end_s && (state_r != ST_IDLE) && !frame_end_s;
        end
    end

    uart_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (timer_load_s),
        .div         (timer_div_s),
        .bit_end     (bit_end_s),
        .bit_pre_end (bit_pre_end_s)
    );

    // Frame FSM with shift register, parity accumulator and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shreg_r    <= {DBIT{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            par_acc_r  <= 1'b0;
            stop_cnt_r <= 1'b0;
            cfg_r      <= '{mode: PAR_NONE, stop2: 1'b0};
            div_r      <= DIV_FLOOR;
            tx_r       <= 1'b1;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            // Raised one clock early so the pulse lands on the frame's last clock
            done_r <= last_stop_s && bit_pre_end_s;

            if (accept_s) begin
                state_r    <= ST_START;
                shreg_r    <= din;
                bit_idx_r  <= {IDX_W{1'b0}};
                par_acc_r  <= 1'b0;
                stop_cnt_r <= 1'b0;
                cfg_r      <= '{mode: parity_mode, stop2: stop2};
                div_r      <= div_clamped_s;
                tx_r       <= 1'b0;
                ready_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        tx_r    <= 1'b1;
                        ready_r <= 1'b1;
                    end
                    ST_START: begin
                        if (bit_end_s) begin
                            state_r   <= ST_DATA;
                            tx_r      <= shreg_r[0];
                            par_acc_r <= par_acc_r ^ shreg_r[0];
                            shreg_r   <= {1'b0, shreg_r[DBIT-1:1]};
                        end
                    end
                    ST_DATA: begin
                        if (bit_end_s) begin
                            if (bit_idx_r == IDX_LAST) begin
                                if (parity_enabled(cfg_r.mode)) begin
                                    state_r <= ST_PARITY;
                                    tx_r    <= parity_bit(cfg_r.mode, par_acc_r);
                                end else begin
                                    state_r    <= ST_STOP;
                                    stop_cnt_r <= 1'b0;
                                    tx_r       <= 1'b1;
                                end
                            end else begin
                                bit_idx_r <= bit_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                                tx_r      <= shreg_r[0];
                                par_acc_r <= par_acc_r ^ shreg_r[0];
                                shreg_r   <= {1'b0, shreg_r[DBIT-1:1]};
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end_s) begin
                            state_r    <= ST_STOP;
                            stop_cnt_r <= 1'b0;
                            tx_r       <= 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (bit_end_s) begin
                            if (last_stop_s) begin
                                state_r <= ST_IDLE;
                                tx_r    <= 1'b1;
                                ready_r <= 1'b1;
                            end else begin
                                stop_cnt_r <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        tx_r    <= 1'b1;
                        ready_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx           = tx_r;
    assign tx_ready     = ready_r;
    assign tx_done_tick = done_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
// Directed bench for uart_tx_cfg. Each accepted byte pushes its expected
// line levels onto a queue; a monitor pops an entry whenever a start bit
// appears on tx and compares every clock of the frame, including the
// position of tx_done_tick.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

    logic        clk;
    logic        rst_n;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        tx_start;
    logic [7:0]  din;
    logic        tx_ready;
    logic        tx_done_tick;
    logic        tx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] bits;   // line level per bit slot, start bit in slot 0
        int          div;
        int          len;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_cfg #(
        .DBIT  (8),
        .DIV_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_div     (baud_div),
        .parity_mode  (parity_mode),
        .stop2        (stop2),
        .tx_start     (tx_start),
        .din          (din),
        .tx_ready     (tx_ready),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected frame: start, 8 data LSB first, optional parity, 1 or 2 stops.
    // exp_par is the hand-computed parity bit for the byte and mode.
    task automatic push_exp(input logic [7:0] d, input logic [15:0] div,
                            input logic [1:0] pm, input logic s2, input logic exp_par);
        exp_t e;
        int   n;
        int   eff;
        e.bits = 12'h000;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
        n = 9;
        if (pm == 2'b01 || pm == 2'b10) begin
            e.bits[n] = exp_par;
            n++;
        end
        e.bits[n] = 1'b1;
        n++;
        if (s2) begin
            e.bits[n] = 1'b1;
            n++;
        end
        eff   = (div < 16'd2) ? 2 : int'(div);
        e.div = eff;
        e.len = n * eff;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=%0b required=1", tx_ready);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [15:0] div,
                        input logic [1:0] pm, input logic s2, input logic exp_par);
        wait_ready();
        din         = d;
        baud_div    = div;
        parity_mode = pm;
        stop2       = s2;
        tx_start    = 1'b1;
        push_exp(d, div, pm, s2, exp_par);
        @(posedge clk);
        #1 tx_start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (tx_done_tick !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (tx_done_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0b required=1", tx_done_tick);
        end
    endtask

    // Monitor: pops one expectation per start bit and checks every clock
    initial begin : monitor
        exp_t        e;
        int          bad_lvl;
        int          bad_done;
        logic [11:0] got;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start actual=frame required=idle");
                    while (tx === 1'b0 && rst_n === 1'b1) @(negedge clk);
                end else begin
                    e        = exp_q.pop_front();
                    bad_lvl  = 0;
                    bad_done = 0;
                    got      = 12'h000;
                    aborted  = 1'b0;
                    for (int k = 0; k < e.len; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx !== e.bits[k / e.div]) bad_lvl++;
                        if (tx_done_tick !== (k == e.len - 1)) bad_done++;
                        if ((k % e.div) == (e.div / 2)) got[k / e.div] = tx;
                    end
                    if (!aborted) begin
                        chk("frame_bits", {20'h0, got}, {20'h0, e.bits});
                        chk("frame_level_errs", bad_lvl, 0);
                        chk("done_pulse_errs", bad_done, 0);
                    end
                end
            end
        end
    end

    // Global time limit
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "time limit");
    end

    // Stimulus
    initial begin : stim
        rst_n       = 1'b1;
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        tx_start    = 1'b0;
        din         = 8'h00;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_ready", tx_ready, 1);
        chk("reset_done", tx_done_tick, 0);
        rst_n = 1'b1;

        // Basic frame: 0x55, div 4, no parity, one stop -> 40 clocks
        send(8'h55, 16'd4, 2'b00, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);
        chk("ready_after_basic", tx_ready, 1);

        // Parity: 0xA7 has five ones -> even parity 1, odd parity 0, 33 clocks
        send(8'hA7, 16'd3, 2'b01, 1'b0, 1'b1);
        wait_done();
        send(8'hA7, 16'd3, 2'b10, 1'b0, 1'b0);
        wait_done();
        // Mode 11 sends no parity bit
        send(8'h0F, 16'd3, 2'b11, 1'b0, 1'b0);
        wait_done();

        // Two stop bits and back-to-back with tx_start held high
        wait_ready();
        din         = 8'h00;
        baud_div    = 16'd3;
        parity_mode = 2'b00;
        stop2       = 1'b1;
        tx_start    = 1'b1;
        push_exp(8'h00, 16'd3, 2'b00, 1'b1, 1'b0);
        push_exp(8'hFF, 16'd3, 2'b00, 1'b1, 1'b0);
        @(posedge clk);
        #1 din = 8'hFF;
        wait_done();
        @(negedge clk);
        chk("b2b_no_gap_tx", tx, 0);
        chk("b2b_ready_low", tx_ready, 0);
        tx_start = 1'b0;
        wait_done();
        @(negedge clk);
        chk("ready_after_b2b", tx_ready, 1);

        // Config and tx_start changes mid-frame are ignored
        send(8'h33, 16'd4, 2'b00, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        baud_div    = 16'd8;
        parity_mode = 2'b01;
        stop2       = 1'b1;
        din         = 8'hEE;
        tx_start    = 1'b1;
        @(negedge clk);
        tx_start    = 1'b0;
        wait_done();
        @(negedge clk);
        chk("ready_after_busy_pulse", tx_ready, 1);
        repeat (3) @(negedge clk);
        chk("no_queued_frame_tx", tx, 1);
        send(8'hC5, 16'd8, 2'b00, 1'b0, 1'b0);
        wait_done();

        // Divisor clamp: 0 and 1 behave as 2 (0x5A has four ones -> even parity 0)
        send(8'h81, 16'd0, 2'b00, 1'b0, 1'b0);
        wait_done();
        send(8'h5A, 16'd1, 2'b01, 1'b1, 1'b0);
        wait_done();

        // Reset in the middle of the data bits
        send(8'h96, 16'd4, 2'b00, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_tx", tx, 1);
        chk("midreset_ready", tx_ready, 1);
        chk("midreset_done", tx_done_tick, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h3C, 16'd4, 2'b00, 1'b0, 1'b0);
        wait_done();
        @(negedge clk);
        chk("ready_after_reset_frame", tx_ready, 1);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
